// File: rtl/usbh_pkt_fifo.sv
// ---------------------------------------------------------------------------
// usbh_pkt_fifo
//   Packet FIFO with commit/abort semantics. The writer pushes entries that
//   stay invisible to the reader until commit_i publishes them; abort_i
//   drops everything written since the last commit. The read side is
//   show-ahead: data_o is the committed head entry with zero latency.
//
// Ports
//   clk_i, rst_i          clock (rising edge), async active-high reset
//   data_i, push_i        write data / write request
//   commit_i, abort_i     publish / discard pending entries (abort wins)
//   pop_i                 advance the committed head
//   flush_i               synchronous clear of all pointers
//   err_clr_i             clear sticky overflow/underflow flags
//   data_o                committed head entry (don't-care while empty)
//   empty_o, full_o       no committed entries / total occupancy == DEPTH
//   level_o, pend_o       committed / uncommitted entry counts
//   afull_o, aempty_o     total >= AFULL_LVL / committed <= AEMPTY_LVL
//   overflow_o            sticky: push seen while full
//   underflow_o           sticky: pop seen while empty
// ---------------------------------------------------------------------------
module usbh_pkt_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 64,
    parameter int ADDR_W     = 6,
    parameter int AFULL_LVL  = 56,
    parameter int AEMPTY_LVL = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [WIDTH-1:0]  data_i,
    input  logic              push_i,
    input  logic              commit_i,
    input  logic              abort_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic              err_clr_i,
    output logic [WIDTH-1:0]  data_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [ADDR_W:0]   level_o,
    output logic [ADDR_W:0]   pend_o,
    output logic              afull_o,
    output logic              aempty_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam logic [ADDR_W:0] DEPTH_P  = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] AFULL_P  = AFULL_LVL[ADDR_W:0];
    localparam logic [ADDR_W:0] AEMPTY_P = AEMPTY_LVL[ADDR_W:0];
    localparam logic [ADDR_W:0] ONE_P    = {{ADDR_W{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_W:0] rd_ptr, cm_ptr, wr_ptr;
    logic [ADDR_W:0] rd_nxt, cm_nxt, wr_nxt;
    logic [ADDR_W:0] wr_post_push;
    logic [ADDR_W:0] level, pend, total;

    logic [WIDTH-1:0] ram [DEPTH];

    logic push_ok, pop_ok;
    logic ovf_set, unf_set;

    assign level = cm_ptr - rd_ptr;
    assign pend  = wr_ptr - cm_ptr;
    assign total = wr_ptr - rd_ptr;

    assign full_o   = (total == DEPTH_P);
    assign empty_o  = (level == '0);
    assign afull_o  = (total >= AFULL_P);
    assign aempty_o = (level <= AEMPTY_P);
    assign level_o  = level;
    assign pend_o   = pend;

    assign data_o = ram[rd_ptr[ADDR_W-1:0]];

    // Acceptance uses the pre-edge flags only; a same-cycle pop never makes
    // room for a push, and a same-cycle push/commit never feeds a pop.
    assign push_ok = push_i & ~full_o & ~flush_i;
    assign pop_ok  = pop_i & ~empty_o & ~flush_i;

    assign ovf_set = push_i & full_o & ~flush_i;
    assign unf_set = pop_i & empty_o & ~flush_i;

    // Commit must include a push accepted in the same cycle.
    assign wr_post_push = push_ok ? (wr_ptr + ONE_P) : wr_ptr;

    always_comb begin
        rd_nxt = rd_ptr;
        cm_nxt = cm_ptr;
        wr_nxt = wr_ptr;
        if (flush_i) begin
            rd_nxt = '0;
            cm_nxt = '0;
            wr_nxt = '0;
        end else begin
            if (pop_ok)
                rd_nxt = rd_ptr + ONE_P;
            if (abort_i) begin
                wr_nxt = cm_ptr;
            end else begin
                wr_nxt = wr_post_push;
                if (commit_i)
                    cm_nxt = wr_post_push;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr      <= '0;
            cm_ptr      <= '0;
            wr_ptr      <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            rd_ptr <= rd_nxt;
            cm_ptr <= cm_nxt;
            wr_ptr <= wr_nxt;
            // Set events beat a same-cycle clear.
            if (ovf_set)
                overflow_o <= 1'b1;
            else if (err_clr_i)
                overflow_o <= 1'b0;
            if (unf_set)
                underflow_o <= 1'b1;
            else if (err_clr_i)
                underflow_o <= 1'b0;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (push_ok)
            ram[wr_ptr[ADDR_W-1:0]] <= data_i;
    end

endmodule

// File: tb/tb_usbh_pkt_fifo.sv
module tb_usbh_pkt_fifo;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;
    localparam int AFULL  = 56;
    localparam int AEMPTY = 8;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [WIDTH-1:0]  data_i;
    logic              push_i, commit_i, abort_i, pop_i, flush_i, err_clr_i;
    logic [WIDTH-1:0]  data_o;
    logic              empty_o, full_o, afull_o, aempty_o, overflow_o, underflow_o;
    logic [ADDR_W:0]   level_o, pend_o;

    usbh_pkt_fifo #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
        .AFULL_LVL(AFULL), .AEMPTY_LVL(AEMPTY)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .data_i(data_i), .push_i(push_i), .commit_i(commit_i), .abort_i(abort_i),
        .pop_i(pop_i), .flush_i(flush_i), .err_clr_i(err_clr_i),
        .data_o(data_o), .empty_o(empty_o), .full_o(full_o),
        .level_o(level_o), .pend_o(pend_o),
        .afull_o(afull_o), .aempty_o(aempty_o),
        .overflow_o(overflow_o), .underflow_o(underflow_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: committed entries and pending entries as queues.
    logic [WIDTH-1:0] cq[$];
    logic [WIDTH-1:0] pq[$];
    bit m_ovf, m_unf;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int tot;
        tot = cq.size() + pq.size();
        check({tag, "_level"}, 32'(level_o), 32'(cq.size()));
        check({tag, "_pend"},  32'(pend_o),  32'(pq.size()));
        check({tag, "_empty"}, 32'(empty_o), 32'(cq.size() == 0));
        check({tag, "_full"},  32'(full_o),  32'(tot == DEPTH));
        check({tag, "_afull"}, 32'(afull_o), 32'(tot >= AFULL));
        check({tag, "_aempty"},32'(aempty_o),32'(cq.size() <= AEMPTY));
        check({tag, "_ovf"},   32'(overflow_o),  32'(m_ovf));
        check({tag, "_unf"},   32'(underflow_o), 32'(m_unf));
        if (cq.size() != 0)
            check({tag, "_data"}, 32'(data_o), 32'(cq[0]));
    endtask

    // One clock: drive inputs, advance the model on the edge, then check.
    task automatic cyc(input string tag, input bit pu, input logic [WIDTH-1:0] d,
                       input bit po, input bit cm, input bit ab, input bit fl, input bit ec);
        bit full_m, empty_m;
        push_i = pu; data_i = d; pop_i = po; commit_i = cm;
        abort_i = ab; flush_i = fl; err_clr_i = ec;
        full_m  = (cq.size() + pq.size()) == DEPTH;
        empty_m = (cq.size() == 0);
        @(posedge clk_i);
        #1;
        if (fl) begin
            cq.delete();
            pq.delete();
        end else begin
            if (pu && !full_m) pq.push_back(d);
            if (po && !empty_m) void'(cq.pop_front());
            if (ab) pq.delete();
            else if (cm) while (pq.size() != 0) cq.push_back(pq.pop_front());
        end
        if (pu && full_m && !fl) m_ovf = 1'b1;
        else if (ec) m_ovf = 1'b0;
        if (po && empty_m && !fl) m_unf = 1'b1;
        else if (ec) m_unf = 1'b0;
        push_i = 0; pop_i = 0; commit_i = 0; abort_i = 0; flush_i = 0; err_clr_i = 0;
        check_all(tag);
    endtask

    initial begin
        logic [7:0] seq [3];
        logic [7:0] exp_d;
        int lvl_before;
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33;
        rst_i = 1'b1; data_i = '0;
        push_i = 0; commit_i = 0; abort_i = 0; pop_i = 0; flush_i = 0; err_clr_i = 0;
        m_ovf = 0; m_unf = 0;
        #12;
        check("rst_empty", 32'(empty_o), 32'd1);
        check("rst_full",  32'(full_o),  32'd0);
        check("rst_level", 32'(level_o), 32'd0);
        check("rst_pend",  32'(pend_o),  32'd0);
        check("rst_aempty",32'(aempty_o),32'd1);
        check("rst_afull", 32'(afull_o), 32'd0);
        check("rst_ovf",   32'(overflow_o),  32'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Basic push/commit/pop ordering.
        for (int i = 0; i < 3; i++) cyc("p27_push", 1, seq[i], 0, 0, 0, 0, 0);
        cyc("p27_commit", 0, 8'h00, 0, 1, 0, 0, 0);
        check("p27_level3", 32'(level_o), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("p27_head", 32'(data_o), 32'(seq[i]));
            cyc("p27_pop", 0, 8'h00, 1, 0, 0, 0, 0);
        end
        check("p27_empty", 32'(empty_o), 32'd1);

        // Abort of a 5-entry packet, then a fresh single-entry packet.
        lvl_before = int'(level_o);
        for (int i = 0; i < 5; i++) cyc("p28_push", 1, 8'(8'h40 + i), 0, 0, 0, 0, 0);
        cyc("p28_abort", 0, 8'h00, 0, 0, 1, 0, 0);
        check("p28_pend0", 32'(pend_o), 32'd0);
        check("p28_lvl_same", 32'(level_o), 32'(lvl_before));
        cyc("p28_pc", 1, 8'hA5, 0, 1, 0, 0, 0);
        check("p28_data", 32'(data_o), 32'hA5);
        cyc("p28_drain", 0, 8'h00, 1, 0, 0, 0, 0);

        // Fill to DEPTH, then push+pop while full.
        for (int i = 0; i < DEPTH; i++)
            cyc("p29_fill", 1, 8'(i * 3 + 1), 0, (i == DEPTH - 1), 0, 0, 0);
        check("p29_full",  32'(full_o),  32'd1);
        check("p29_afull", 32'(afull_o), 32'd1);
        cyc("p29_pushpop", 1, 8'hEE, 1, 0, 0, 0, 0);
        check("p29_ovf", 32'(overflow_o), 32'd1);
        check("p29_lvl63", 32'(level_o), 32'd63);
        cyc("p29_clr", 0, 8'h00, 0, 0, 0, 0, 1);
        check("p29_ovf_clr", 32'(overflow_o), 32'd0);
        cyc("p29_flush", 1, 8'h99, 1, 1, 0, 1, 0);
        check("p29_flush_lvl", 32'(level_o), 32'd0);

        // Pop while empty with a same-cycle push+commit.
        cyc("p30", 1, 8'h7E, 1, 1, 0, 0, 0);
        check("p30_unf", 32'(underflow_o), 32'd1);
        check("p30_lvl", 32'(level_o), 32'd1);
        check("p30_data", 32'(data_o), 32'h7E);
        cyc("p30_clr", 0, 8'h00, 1, 0, 0, 0, 1);

        // 200 packets of 3 with interleaved pops across many wraps.
        exp_d = 8'h00;
        for (int p = 0; p < 200; p++)
            for (int k = 0; k < 3; k++) begin
                cyc("p31", 1, exp_d, ($urandom_range(0, 3) != 0), (k == 2), 0, 0, 0);
                exp_d = exp_d + 8'd1;
            end
        while (cq.size() != 0) cyc("p31_drain", 0, 8'h00, 1, 0, 0, 0, 0);
        check("p31_drained", 32'(empty_o), 32'd1);

        // Randomized mix of all controls.
        for (int i = 0; i < 3000; i++)
            cyc("rnd", ($urandom_range(0, 9) < 6), 8'($urandom), ($urandom_range(0, 9) < 5),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 127) == 0), ($urandom_range(0, 15) == 0));

        // Asynchronous reset in the middle of a packet.
        cyc("p32_flush", 0, 8'h00, 0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) cyc("p32_push", 1, 8'(8'hC0 + i), 0, (i == 3), 0, 0, 0);
        for (int i = 0; i < 2; i++) cyc("p32_pend", 1, 8'(8'hD0 + i), 0, 0, 0, 0, 0);
        check("p32_pre_lvl",  32'(level_o), 32'd4);
        check("p32_pre_pend", 32'(pend_o),  32'd2);
        #2;
        rst_i = 1'b1;
        #1;
        check("p32_lvl",   32'(level_o), 32'd0);
        check("p32_pend",  32'(pend_o),  32'd0);
        check("p32_empty", 32'(empty_o), 32'd1);
        check("p32_full",  32'(full_o),  32'd0);
        cq.delete(); pq.delete(); m_ovf = 0; m_unf = 0;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        cyc("post_rst", 1, 8'h5A, 0, 1, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
